// File: rtl/wl_pkg.sv
// ---------------------------------------------------------------------------
// wl_pkg
// Shared types and constants for the core data-port demultiplexer.
//   - core_data_req_t / core_data_rsp_t : core LSU request/response bundles
//   - addr_napot_demux_rule_t           : one NAPOT decode rule (idx, base, mask)
//   - CoreDataNumPorts / CoreDataMaxOutstanding / CoreDataAddrMap
// ---------------------------------------------------------------------------
package wl_pkg;

  localparam int unsigned CoreDataNumPorts       = 3;
  localparam int unsigned CoreDataMaxOutstanding = 4;

  // Target regions: base address and power-of-two region size.
  localparam logic [31:0] DataMemBase   = 32'h0002_0000;
  localparam logic [31:0] DataMemOffset = 32'h0002_0000;
  localparam logic [31:0] CsrBase       = 32'h0004_0000;
  localparam logic [31:0] CsrOffset     = 32'h0001_0000;
  localparam logic [31:0] HwpeCfgBase   = 32'h0008_0000;
  localparam logic [31:0] HwpeCfgOffset = 32'h0001_0000;

  typedef struct packed {
    logic [31:0] idx;
    logic [31:0] base;
    logic [31:0] mask;
  } addr_napot_demux_rule_t;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } core_data_req_chan_t;

  typedef struct packed {
    logic [31:0] data;
    logic        error;
  } core_data_rsp_chan_t;

  typedef struct packed {
    logic                q_valid;
    core_data_req_chan_t q;
    logic                p_ready;
  } core_data_req_t;

  typedef struct packed {
    logic                q_ready;
    logic                p_valid;
    core_data_rsp_chan_t p;
  } core_data_rsp_t;

  // A NAPOT region of size 'offset' matches every address whose upper bits
  // equal the base, so the mask clears the in-region offset bits.
  function automatic logic [31:0] napot_mask(input logic [31:0] offset);
    return ~(offset - 32'd1);
  endfunction

  // Packed array: the leftmost element is index CoreDataNumPorts-1.
  localparam addr_napot_demux_rule_t [CoreDataNumPorts-1:0] CoreDataAddrMap = '{
    '{idx: 32'd2, base: HwpeCfgBase, mask: napot_mask(HwpeCfgOffset)},
    '{idx: 32'd1, base: CsrBase,     mask: napot_mask(CsrOffset)},
    '{idx: 32'd0, base: DataMemBase, mask: napot_mask(DataMemOffset)}
  };

endpackage

// File: rtl/fifo_v3.sv
// ---------------------------------------------------------------------------
// fifo_v3
// Small synchronous FIFO with optional fall-through.
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset
//   flush_i : synchronous clear of all entries
//   full_o  : no free entry
//   empty_o : no valid entry at the output
//   data_i / push_i : write side (push ignored when full)
//   data_o / pop_i  : read side (pop ignored when empty)
// ---------------------------------------------------------------------------
module fifo_v3 #(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  output logic                  full_o,
  output logic                  empty_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);

  localparam int unsigned AddrDepth = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AddrDepth-1:0] LastPtr = AddrDepth'(DEPTH - 1);
  localparam logic [AddrDepth:0]   FullCnt = (AddrDepth + 1)'(DEPTH);

  logic [AddrDepth-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AddrDepth-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AddrDepth:0]    cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic                  mem_we;
  logic                  push_ok;
  logic                  pop_ok;
  logic                  bypass;

  // In fall-through mode an empty FIFO forwards data_i directly.
  assign bypass  = FALL_THROUGH && (cnt_q == '0);
  assign full_o  = (cnt_q == FullCnt);
  assign empty_o = (cnt_q == '0) && !(FALL_THROUGH && push_i);
  assign data_o  = bypass ? data_i : mem_q[rd_ptr_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    mem_we   = 1'b0;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      // A bypassed push that is popped in the same cycle never gets stored.
      if (push_ok && !(bypass && pop_ok)) begin
        mem_we   = 1'b1;
        wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
        cnt_d    = cnt_d + 1'b1;
      end
      if (pop_ok && !bypass) begin
        rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
        cnt_d    = cnt_d - 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/wl_core_data_demux.sv
// ---------------------------------------------------------------------------
// wl_core_data_demux
// Routes core LSU requests to one of NumPorts targets by NAPOT address decode
// and returns responses strictly in request order.
//   clk_i     : clock, all state on rising edge
//   rst_i     : asynchronous active-high reset
//   slv_req_i : core request (q_valid, q, p_ready)
//   slv_rsp_o : core response (q_ready, p_valid, p)
//   mst_req_o : per-target request, payload broadcast, q_valid one-hot
//   mst_rsp_i : per-target response
//   idle_o    : no request outstanding
//
// Handshakes: a request transfers in a cycle where q_valid && q_ready are
// both high at the rising edge; a response transfers where p_valid && p_ready
// are both high. The requester keeps q stable while q_valid && !q_ready.
// Addresses that match no rule go to an internal error target which answers
// with data 0 and error 1 once it reaches the head of the order FIFO.
// ---------------------------------------------------------------------------
module wl_core_data_demux
  import wl_pkg::*;
#(
  parameter int unsigned NumPorts       = CoreDataNumPorts,
  parameter int unsigned MaxOutstanding = CoreDataMaxOutstanding,
  parameter addr_napot_demux_rule_t [NumPorts-1:0] AddrMap = CoreDataAddrMap
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  core_data_req_t slv_req_i,
  output core_data_rsp_t slv_rsp_o,
  output core_data_req_t mst_req_o [NumPorts],
  input  core_data_rsp_t mst_rsp_i [NumPorts],
  output logic           idle_o
);

  localparam int unsigned SelW = $clog2(NumPorts + 1);
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  typedef logic [SelW-1:0] sel_t;
  localparam sel_t            ErrSel = sel_t'(NumPorts);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);

  logic [CntW-1:0] count_q, count_d;
  sel_t            sel;
  sel_t            head;
  logic            fifo_full;
  logic            fifo_empty;
  logic            can_accept;
  logic            tgt_q_ready;
  logic            q_ready;
  logic            p_valid;
  logic            push;
  logic            pop;

  // Scan from the highest rule down so the lowest matching index wins.
  always_comb begin
    sel = ErrSel;
    for (int i = int'(NumPorts) - 1; i >= 0; i--) begin
      if ((slv_req_i.q.addr & AddrMap[i].mask) == (AddrMap[i].base & AddrMap[i].mask)) begin
        sel = AddrMap[i].idx[SelW-1:0];
      end
    end
  end

  // Acceptance depends only on the current count, never on this cycle's pop,
  // so there is no combinational path from p_ready to q_ready.
  assign can_accept = !rst_i && (count_q < MaxCnt) && !fifo_full;

  always_comb begin
    tgt_q_ready = 1'b1;
    for (int i = 0; i < int'(NumPorts); i++) begin
      if (sel == sel_t'(i)) begin
        tgt_q_ready = mst_rsp_i[i].q_ready;
      end
    end
  end

  assign q_ready = tgt_q_ready && can_accept;
  assign push    = slv_req_i.q_valid && q_ready;

  always_comb begin
    for (int i = 0; i < int'(NumPorts); i++) begin
      mst_req_o[i].q       = slv_req_i.q;
      mst_req_o[i].q_valid = slv_req_i.q_valid && can_accept && (sel == sel_t'(i));
      mst_req_o[i].p_ready = !rst_i && !fifo_empty && (head == sel_t'(i)) && slv_req_i.p_ready;
    end
  end

  // Only the port at the FIFO head may present a response; others are held.
  always_comb begin
    p_valid           = 1'b0;
    slv_rsp_o.p       = '0;
    if (!rst_i && !fifo_empty) begin
      if (head == ErrSel) begin
        p_valid           = 1'b1;
        slv_rsp_o.p.data  = '0;
        slv_rsp_o.p.error = 1'b1;
      end else begin
        for (int i = 0; i < int'(NumPorts); i++) begin
          if (head == sel_t'(i)) begin
            p_valid     = mst_rsp_i[i].p_valid;
            slv_rsp_o.p = mst_rsp_i[i].p;
          end
        end
      end
    end
  end

  assign slv_rsp_o.q_ready = q_ready;
  assign slv_rsp_o.p_valid = p_valid;
  assign pop               = p_valid && slv_req_i.p_ready;

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign idle_o = (count_q == '0);

  fifo_v3 #(
    .FALL_THROUGH (1'b0),
    .DATA_WIDTH   (SelW),
    .DEPTH        (MaxOutstanding)
  ) i_idx_fifo (
    .clk_i   (clk_i),
    .rst_ni  (~rst_i),
    .flush_i (1'b0),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .data_i  (sel),
    .push_i  (push),
    .data_o  (head),
    .pop_i   (pop)
  );

endmodule

// File: tb/tb_wl_core_data_demux.sv
// ---------------------------------------------------------------------------
// tb_wl_core_data_demux
// Directed and randomised traffic against wl_core_data_demux with behavioural
// downstream targets and an in-order response scoreboard.
// ---------------------------------------------------------------------------
module tb_wl_core_data_demux;
  import wl_pkg::*;

  localparam int NP = CoreDataNumPorts;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  core_data_req_t slv_req;
  core_data_rsp_t slv_rsp;
  core_data_req_t mst_req [NP];
  core_data_rsp_t mst_rsp [NP];
  logic           idle;

  wl_core_data_demux dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .slv_req_i (slv_req),
    .slv_rsp_o (slv_rsp),
    .mst_req_o (mst_req),
    .mst_rsp_i (mst_rsp),
    .idle_o    (idle)
  );

  int errors = 0;
  int checks = 0;

  logic [32:0] exp_q [$];          // {error, data} in expected order
  logic [31:0] pend_q [NP][$];     // per-target pending response data
  logic        tgt_rsp_en [NP];
  logic        tgt_flush;
  logic        rand_mode;

  function automatic logic [31:0] rsp_data(input logic [31:0] a, input int p);
    return a ^ 32'hC0DE_0000 ^ ((32'(p) + 32'd1) << 28);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [NP-1:0] mst_qv_vec();
    logic [NP-1:0] v;
    for (int p = 0; p < NP; p++) v[p] = mst_req[p].q_valid;
    return v;
  endfunction

  function automatic logic [NP-1:0] mst_pr_vec();
    logic [NP-1:0] v;
    for (int p = 0; p < NP; p++) v[p] = mst_req[p].p_ready;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send(input logic [31:0] addr, input logic we, input logic [31:0] wdata, input int port);
    int n;
    logic [NP-1:0] ev;
    slv_req.q.addr  = addr;
    slv_req.q.we    = we;
    slv_req.q.be    = 4'hF;
    slv_req.q.wdata = wdata;
    slv_req.q_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!slv_rsp.q_ready && n < 300);
    if (!slv_rsp.q_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: addr 0x%0h never accepted", addr);
    end else begin
      ev = (port < NP) ? (NP'(1) << port) : '0;
      check("route", 64'(mst_qv_vec()), 64'(ev));
      if (port < NP) check("payload", {mst_req[port].q.addr, mst_req[port].q.wdata}, {addr, wdata});
      exp_q.push_back((port < NP) ? {1'b0, rsp_data(addr, port)} : {1'b1, 32'h0});
    end
    @(posedge clk);
    #1;
    slv_req.q_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !idle) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_idle", {62'd0, exp_q.size() == 0, idle}, 64'd3);
  endtask

  // ---------------- downstream target models ----------------
  initial begin
    logic        hs_q [NP];
    logic        hs_p [NP];
    logic [31:0] a    [NP];
    logic        pv;
    forever begin
      @(negedge clk);
      for (int p = 0; p < NP; p++) begin
        hs_q[p] = mst_req[p].q_valid && mst_rsp[p].q_ready;
        hs_p[p] = mst_rsp[p].p_valid && mst_req[p].p_ready;
        a[p]    = mst_req[p].q.addr;
      end
      @(posedge clk);
      #1;
      for (int p = 0; p < NP; p++) begin
        if (tgt_flush) begin
          pend_q[p].delete();
          pv = 1'b0;
        end else begin
          if (hs_p[p] && pend_q[p].size() != 0) void'(pend_q[p].pop_front());
          if (hs_q[p]) pend_q[p].push_back(rsp_data(a[p], p));
          // A presented response stays up until taken.
          if (mst_rsp[p].p_valid && !hs_p[p]) pv = 1'b1;
          else pv = (pend_q[p].size() != 0) && tgt_rsp_en[p] &&
                    (!rand_mode || $urandom_range(0, 2) != 0);
        end
        mst_rsp[p].p_valid  = pv;
        mst_rsp[p].p.data   = pv ? pend_q[p][0] : 32'h0;
        mst_rsp[p].p.error  = 1'b0;
        mst_rsp[p].q_ready  = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  end

  // Random upstream response back-pressure.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_mode) slv_req.p_ready = ($urandom_range(0, 1) != 0);
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [32:0] e;
    forever begin
      @(negedge clk);
      if (!rst && slv_rsp.p_valid && slv_req.p_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: data 0x%0h error %0b with nothing expected",
                   slv_rsp.p.data, slv_rsp.p.error);
        end else begin
          e = exp_q.pop_front();
          check("rsp", 64'({slv_rsp.p.error, slv_rsp.p.data}), 64'(e));
        end
      end
    end
  end

  // Upstream payload must stay stable while a request is stalled.
  initial begin
    core_data_req_chan_t pq;
    logic pv;
    logic pr;
    pv = 1'b0;
    pr = 1'b0;
    pq = '0;
    forever begin
      @(negedge clk);
      if (!rst && pv && !pr && slv_req.q_valid) begin
        checks++;
        if (slv_req.q !== pq) begin
          errors++;
          $display("FAIL q_stable: payload changed while stalled");
        end
      end
      pv = slv_req.q_valid && !rst;
      pr = slv_rsp.q_ready;
      pq = slv_req.q;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] bases [4];
    int r;
    bases[0] = 32'h0002_0000;
    bases[1] = 32'h0004_0000;
    bases[2] = 32'h0008_0000;
    bases[3] = 32'h0010_0000;

    rst       = 1'b1;
    rand_mode = 1'b0;
    tgt_flush = 1'b0;
    slv_req   = '0;
    for (int p = 0; p < NP; p++) begin
      tgt_rsp_en[p]      = 1'b1;
      mst_rsp[p]         = '0;
      mst_rsp[p].q_ready = 1'b1;
    end
    slv_req.q_valid = 1'b1;
    slv_req.q.addr  = 32'h0002_0000;
    slv_req.p_ready = 1'b1;

    // Reset state with a request pending.
    @(negedge clk);
    check("rst_idle", 64'(idle), 64'd1);
    check("rst_q_ready", 64'(slv_rsp.q_ready), 64'd0);
    check("rst_p_valid", 64'(slv_rsp.p_valid), 64'd0);
    check("rst_mst_q_valid", 64'(mst_qv_vec()), 64'd0);
    check("rst_mst_p_ready", 64'(mst_pr_vec()), 64'd0);
    @(posedge clk);
    #1;
    slv_req.q_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Write to DataMem.
    send(32'h0002_0004, 1'b1, 32'hDEAD_BEEF, 0);
    wait_drain(50);

    // Csr then HwpeCfg; HwpeCfg answers first and must be held.
    @(posedge clk);
    #1;
    tgt_rsp_en[1] = 1'b0;
    send(32'h0004_0000, 1'b0, 32'h0, 1);
    send(32'h0008_0000, 1'b0, 32'h0, 2);
    repeat (3) @(negedge clk);
    check("held_slv_p_valid", 64'(slv_rsp.p_valid), 64'd0);
    check("hwpe_p_valid_up", 64'(mst_rsp[2].p_valid), 64'd1);
    check("hwpe_p_ready_held", 64'(mst_req[2].p_ready), 64'd0);
    @(posedge clk);
    #1;
    tgt_rsp_en[1] = 1'b1;
    wait_drain(50);

    // Unmapped address answers from the error target one cycle later.
    @(posedge clk);
    #1;
    send(32'h0010_0000, 1'b0, 32'h0, NP);
    @(negedge clk);
    check("err_p_valid", 64'(slv_rsp.p_valid), 64'd1);
    check("err_payload", 64'({slv_rsp.p.error, slv_rsp.p.data}), 64'({1'b1, 32'h0}));
    wait_drain(50);

    // Outstanding limit.
    @(posedge clk);
    #1;
    slv_req.p_ready = 1'b0;
    for (int k = 0; k < 4; k++) send(32'h0002_0000, 1'b0, 32'h0, 0);
    fork
      send(32'h0002_0000, 1'b0, 32'h0, 0);
    join_none
    repeat (2) @(negedge clk);
    check("full_q_ready", 64'(slv_rsp.q_ready), 64'd0);
    check("full_idle", 64'(idle), 64'd0);
    check("full_mst_q_valid", 64'(mst_qv_vec()), 64'd0);
    @(posedge clk);
    #1;
    slv_req.p_ready = 1'b1;
    @(negedge clk);
    check("full_pop_valid", 64'(slv_rsp.p_valid), 64'd1);
    check("full_pop_no_push", 64'(slv_rsp.q_ready), 64'd0);
    @(posedge clk);
    #1;
    slv_req.p_ready = 1'b0;
    @(negedge clk);
    check("after_pop_q_ready", 64'(slv_rsp.q_ready), 64'd1);
    wait fork;
    @(posedge clk);
    #1;
    slv_req.p_ready = 1'b1;
    wait_drain(100);

    // Reset with two outstanding.
    @(posedge clk);
    #1;
    tgt_rsp_en[1] = 1'b0;
    tgt_rsp_en[2] = 1'b0;
    slv_req.p_ready = 1'b0;
    send(32'h0004_0000, 1'b0, 32'h0, 1);
    send(32'h0008_0000, 1'b0, 32'h0, 2);
    @(negedge clk);
    check("two_out_idle", 64'(idle), 64'd0);
    @(posedge clk);
    #1;
    tgt_rsp_en[1] = 1'b1;
    tgt_rsp_en[2] = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    slv_req.q_valid = 1'b1;
    slv_req.q.addr  = 32'h0002_0000;
    @(negedge clk);
    check("mid_rst_idle", 64'(idle), 64'd1);
    check("mid_rst_q_ready", 64'(slv_rsp.q_ready), 64'd0);
    check("mid_rst_p_valid", 64'(slv_rsp.p_valid), 64'd0);
    check("mid_rst_mst_q_valid", 64'(mst_qv_vec()), 64'd0);
    check("mid_rst_mst_p_ready", 64'(mst_pr_vec()), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    slv_req.q_valid = 1'b0;
    slv_req.p_ready = 1'b1;
    @(negedge clk);
    check("late_rsp_dropped", 64'(slv_rsp.p_valid), 64'd0);
    check("late_rsp_p_ready", 64'(mst_pr_vec()), 64'd0);
    check("post_rst_idle", 64'(idle), 64'd1);
    @(posedge clk);
    #1;
    tgt_flush = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tgt_flush = 1'b0;
    send(32'h0002_0000, 1'b0, 32'h0, 0);
    wait_drain(50);

    // Random mapped/unmapped mix with stalls on both sides.
    @(posedge clk);
    #1;
    rand_mode = 1'b1;
    for (int k = 0; k < 30; k++) begin
      r = $urandom_range(0, 3);
      send(bases[r] + 32'($urandom_range(0, 255)) * 32'd4, 1'($urandom_range(0, 1)),
           32'($urandom), (r < NP) ? r : NP);
    end
    rand_mode = 1'b0;
    @(posedge clk);
    #1;
    slv_req.p_ready = 1'b1;
    wait_drain(1000);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
